icache_2way: RTL and testbench
==============================

// Module: icache_2way
// PURPOSE
//  2-way set-associative instruction cache with multi-word lines, LRU replacement and a flush.
//  Sits between the instruction fetch unit and the memory controller.
//  Single-cycle combinational hit path; on a miss, refills one full line word by word.
//  Covers a 17-bit byte address space with the defaults.
// PARAMETERS
//  BLOCK_OFFSET  2  log2(words per line); default gives 4 words = 16 B per line
//  INDEX_WIDTH   6  log2(sets); default gives 64 sets x 2 ways
//  TAG_WIDTH     7  tag bits stored per line
// PORTS
//  clockIn   in   1   clock; all state updates on the rising edge
//  resetIn   in   1   synchronous, active-low reset
//  readyIn   in   1   global enable; when low, all state holds (except reset and flush)
//  addrIn    in   32  fetch byte address from the instruction unit
//  hit       out  1   combinational: addrIn is present and valid in either way
//  dataOut   out  32  combinational: hitting word; don't-care when hit=0
//  flushIn   in   1   invalidate the whole cache (fence.i)
//  validIn   in   1   memory controller: dataIn holds the word for addrOut
//  dataIn    in   32  memory controller return data
//  memFlag   out  1   read request to the memory controller, held until the line is complete
//  addrOut   out  32  word-aligned address of the word currently requested
// BEHAVIOUR
//  Address fields:
//   addr[1:0]: ignored.
//   addr[BLOCK_OFFSET+1:2]: word offset.
//   addr[BLOCK_OFFSET+INDEX_WIDTH+1:BLOCK_OFFSET+2]: index.
//   Next TAG_WIDTH bits: tag. Upper bits are ignored.
//  Per set: 2 ways of {valid, tag, 2**BLOCK_OFFSET x 32 data}, plus 1 LRU bit naming the victim way.
//  Reset (resetIn=0 at an edge):
//   All valid=0, all LRU=0, state=IDLE.
//   memFlag=0, addrOut=0. Reset overrides every other input.
//  Priority: reset > flushIn > readyIn=0 (stall) > normal operation.
//  Lookup:
//   hit = OR over ways of (valid & tag match). dataOut = the matching way's word at the offset.
//   Both ways never match at once (fill invalidates the victim first).
//   Lookup is live in both states. A line being filled has valid=0 and never hits.
//  LRU update: on an edge with readyIn=1 and hit=1, LRU[index] <= the way that did not hit.
//  State machine:
//   IDLE -> FILL on an edge with readyIn=1, hit=0 and no flush. At that edge:
//    victim way = LRU[index]; its valid is cleared and its tag is written;
//    fill base = addrIn with offset and [1:0] zeroed; word counter = 0;
//    memFlag<=1; addrOut<=base.
//    Miss-to-memFlag latency: 1 cycle.
//   FILL, on an edge with readyIn=1 and validIn=1:
//    write dataIn into the victim at the counter; increment the counter;
//    addrOut <= base + 4*(counter+1).
//   FILL -> IDLE on the edge accepting the last word (counter = 2**BLOCK_OFFSET-1).
//    Victim valid<=1, LRU[set] <= other way, memFlag<=0.
//    The re-presented addrIn hits on the following cycle.
//  validIn in IDLE, or validIn while readyIn=0, is ignored (no write, no count).
//  During FILL, misses on other addresses issue no request; hit stays 0 for them.
//   A fill is never aborted by a change of addrIn.
//   A hit to another set or way during FILL is served and updates LRU.
//  Counter wrap: the counter is BLOCK_OFFSET bits; it returns to 0 on completion.
//   addrOut never crosses the line.
//  flushIn=1 at an edge (any readyIn, any state):
//   all valid=0, LRU=0, state=IDLE, memFlag<=0.
//   An in-progress fill is dropped. The memory controller discards its outstanding request when memFlag falls.
//   Flush together with validIn: the data is discarded.
//  Width rule: all address arithmetic is 32-bit unsigned. Tag and index are taken from the latched fill base.
// TESTING
//  Reset with resetIn=0 for 2 cycles, release -> memFlag=0, addrOut=0, hit=0 for addrIn=0x0000.
//  Cold miss at 0x104, memory returns 0xA0..0xA3 one per cycle:
//   -> memFlag rises the next cycle; addrOut steps 0x100,0x104,0x108,0x10C;
//   -> memFlag falls after the 4th word; next cycle hit=1, dataOut=0xA1.
//  Fill 0x0100 (way0), then 0x4100 (same set, way1); read 0x0100 (hit); miss 0x8100
//   -> 0x4100 is evicted (LRU); 0x0100 and 0x8100 hit afterwards.
//  readyIn=0 for 3 cycles mid-fill with validIn pulsing
//   -> no words written, addrOut frozen; the fill resumes correctly after readyIn=1.
//  flushIn pulse during the 2nd word of a fill of 0x200
//   -> memFlag=0 next cycle; 0x200 and previously filled 0x100 both miss afterwards.
//  During a fill of 0x300, present 0x104 (resident)
//   -> hit=1, correct data, no new request; the 0x300 fill completes unchanged.

Source files
------------

// File: rtl/icache_2way.sv
`default_nettype none
// ============================================================================
//  Module      : icache_2way
//  Description : 2-way set-associative instruction cache. Combinational hit
//                path, LRU victim selection, word-by-word line refill from
//                the memory controller and a whole-cache flush.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_2way #(
    parameter int BLOCK_OFFSET = 2,
    parameter int INDEX_WIDTH  = 6,
    parameter int TAG_WIDTH    = 7
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic [31:0] addrIn,
    output logic        hit,
    output logic [31:0] dataOut,
    input  logic        flushIn,
    input  logic        validIn,
    input  logic [31:0] dataIn,
    output logic        memFlag,
    output logic [31:0] addrOut
);

    localparam int c_SETS    = 2**INDEX_WIDTH;
    localparam int c_IDX_LSB = BLOCK_OFFSET + 2;
    localparam int c_TAG_LSB = BLOCK_OFFSET + INDEX_WIDTH + 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                    state_q;
    logic                      memFlag_q;
    logic [31:0]               addrOut_q;
    logic [31:0]               base_q;
    logic                      victim_q;
    logic [BLOCK_OFFSET-1:0]   cnt_q;
    logic [BLOCK_OFFSET-1:0]   cnt_d;
    logic [31:0]               addr_d;

    logic [c_SETS-1:0]         valid_q [0:1];
    logic [c_SETS-1:0]         lru_q;
    logic [TAG_WIDTH-1:0]      tag_q   [0:1][0:c_SETS-1];
    logic [31:0]               data_q  [0:1][0:(c_SETS<<BLOCK_OFFSET)-1];

    logic [BLOCK_OFFSET-1:0]   w_off;
    logic [INDEX_WIDTH-1:0]    w_idx;
    logic [INDEX_WIDTH-1:0]    w_fill_idx;
    logic [TAG_WIDTH-1:0]      w_tag;
    logic [31:0]               w_base;
    logic [1:0]                w_way_hit;
    logic                      w_hit_way;
    logic                      w_unused;

    // Fetch address split into offset / index / tag; byte bits are don't-care
    assign w_off      = addrIn[BLOCK_OFFSET+1:2];
    assign w_idx      = addrIn[c_TAG_LSB-1:c_IDX_LSB];
    assign w_tag      = addrIn[c_TAG_LSB +: TAG_WIDTH];
    assign w_base     = {addrIn[31:c_IDX_LSB], {c_IDX_LSB{1'b0}}};
    assign w_unused   = ^addrIn[1:0];

    // Fill bookkeeping uses the latched base so addrIn may wander during a fill
    assign w_fill_idx = base_q[c_TAG_LSB-1:c_IDX_LSB];
    assign cnt_d      = cnt_q + BLOCK_OFFSET'(1);
    // cnt_d wraps to zero on the last word, so addrOut returns to the line base
    assign addr_d     = base_q + {{(30-BLOCK_OFFSET){1'b0}}, cnt_d, 2'b00};

    // Per-way tag compare; a line under refill is invalid and cannot match
    for (genvar w = 0; w < 2; w++) begin : g_way
        assign w_way_hit[w] = valid_q[w][w_idx] && (tag_q[w][w_idx] == w_tag);
    end

    assign hit       = |w_way_hit;
    assign w_hit_way = w_way_hit[1];
    assign dataOut   = data_q[w_hit_way][{w_idx, w_off}];
    assign memFlag   = memFlag_q;
    assign addrOut   = addrOut_q;

    // Control FSM: valid/LRU bookkeeping, refill sequencing, memory request
    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            state_q    <= S_IDLE;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
            memFlag_q  <= 1'b0;
            addrOut_q  <= '0;
            base_q     <= '0;
            victim_q   <= 1'b0;
            cnt_q      <= '0;
        end else if (flushIn) begin
            state_q    <= S_IDLE;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
            memFlag_q  <= 1'b0;
            cnt_q      <= '0;
        end else if (readyIn) begin
            if (hit) begin
                lru_q[w_idx] <= ~w_hit_way;
            end
            case (state_q)
                S_IDLE: begin
                    if (!hit) begin
                        victim_q                  <= lru_q[w_idx];
                        valid_q[lru_q[w_idx]][w_idx] <= 1'b0;
                        base_q                    <= w_base;
                        cnt_q                     <= '0;
                        memFlag_q                 <= 1'b1;
                        addrOut_q                 <= w_base;
                        state_q                   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (validIn) begin
                        cnt_q     <= cnt_d;
                        addrOut_q <= addr_d;
                        if (&cnt_q) begin
                            valid_q[victim_q][w_fill_idx] <= 1'b1;
                            lru_q[w_fill_idx]             <= ~victim_q;
                            memFlag_q                     <= 1'b0;
                            state_q                       <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage: tag claimed at the miss, words written as they return
    always_ff @(posedge clockIn) begin
        if (resetIn && !flushIn && readyIn) begin
            if (state_q == S_IDLE && !hit) begin
                tag_q[lru_q[w_idx]][w_idx] <= w_tag;
            end
            if (state_q == S_FILL && validIn) begin
                data_q[victim_q][{w_fill_idx, cnt_q}] <= dataIn;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_2way.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_2way
//  Description : Self-checking bench for icache_2way. A line-level reference
//                model (per-set recency lists of resident lines, fixed memory
//                contents) predicts every cycle's outputs into a scoreboard
//                queue; a monitor process pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_2way;

    logic        clk;
    logic        resetIn;
    logic        readyIn;
    logic [31:0] addrIn;
    logic        hit;
    logic [31:0] dataOut;
    logic        flushIn;
    logic        validIn;
    logic [31:0] dataIn;
    logic        memFlag;
    logic [31:0] addrOut;

    icache_2way dut (
        .clockIn (clk),
        .resetIn (resetIn),
        .readyIn (readyIn),
        .addrIn  (addrIn),
        .hit     (hit),
        .dataOut (dataOut),
        .flushIn (flushIn),
        .validIn (validIn),
        .dataIn  (dataIn),
        .memFlag (memFlag),
        .addrOut (addrOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [31:0] data;
        logic        mf;
        logic [31:0] ao;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: each set holds up to two resident line keys
    // (addr[16:4]), least recently used first.
    logic [12:0] res [64][$];
    bit          have_reset = 1'b0;
    bit          m_filling  = 1'b0;
    logic [31:0] m_base     = '0;
    int          m_done     = 0;
    logic [31:0] m_ao       = '0;

    // Fixed memory image: line 0x100 holds 0xA0..0xA3; only addr[16:2] matter
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] key;
        key = 32'(a[16:4]);
        return (key - 32'h10) * 32'h0001_0100 + 32'hA0 + 32'(a[3:2]);
    endfunction

    function automatic int find(input logic [12:0] k);
        int s;
        s = int'(k[5:0]);
        for (int i = 0; i < res[s].size(); i++)
            if (res[s][i] == k) return i;
        return -1;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 64; i++) res[i].delete();
        m_filling = 1'b0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[16:10] = 7'($urandom_range(3) * 21);
        case ($urandom_range(3))
            0:       a[9:4] = 6'h00;
            1:       a[9:4] = 6'h10;
            2:       a[9:4] = 6'h11;
            default: a[9:4] = 6'h3F;
        endcase
        return a;
    endfunction

    // One clock cycle: drive inputs, predict this cycle's outputs, advance model
    task automatic step(input logic [31:0] a, input bit rdy, input bit fl,
                        input bit rn, input int vprob);
        exp_t        e;
        logic [12:0] k;
        logic [12:0] fk;
        int          s;
        int          hi;
        @(negedge clk);
        addrIn  = a;
        readyIn = rdy;
        flushIn = fl;
        resetIn = rn;
        validIn = (int'($urandom_range(99)) < vprob);
        dataIn  = memFlag ? mem_word(addrOut) : $urandom;
        #1;
        k  = a[16:4];
        s  = int'(k[5:0]);
        hi = find(k);
        if (have_reset) begin
            e.hit  = (hi >= 0);
            e.data = mem_word(a);
            e.mf   = m_filling;
            e.ao   = m_ao;
            sb.push_back(e);
        end
        if (!rn) begin
            clear_model();
            m_ao       = '0;
            have_reset = 1'b1;
        end else if (have_reset && fl) begin
            clear_model();
        end else if (have_reset && rdy) begin
            if (hi >= 0) begin
                res[s].delete(hi);
                res[s].push_back(k);
            end
            if (!m_filling) begin
                if (hi < 0) begin
                    if (res[s].size() == 2) void'(res[s].pop_front());
                    m_filling = 1'b1;
                    m_base    = a & ~32'hF;
                    m_done    = 0;
                    m_ao      = m_base;
                end
            end else if (validIn) begin
                m_done++;
                if (m_done == 4) begin
                    fk        = m_base[16:4];
                    res[int'(fk[5:0])].push_back(fk);
                    m_filling = 1'b0;
                    m_ao      = m_base;
                end else begin
                    m_ao = m_base + 32'(4 * m_done);
                end
            end
        end
    endtask

    // Monitor: compare DUT outputs against queued predictions
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL hit: got %b expected %b addr=%h t=%0t", hit, e.hit, addrIn, $time);
                end
                if (e.hit) begin
                    n_checks++;
                    if (dataOut !== e.data) begin
                        n_fail++;
                        $display("FAIL dataOut: got %h expected %h addr=%h t=%0t", dataOut, e.data, addrIn, $time);
                    end
                end
                n_checks++;
                if (memFlag !== e.mf) begin
                    n_fail++;
                    $display("FAIL memFlag: got %b expected %b t=%0t", memFlag, e.mf, $time);
                end
                n_checks++;
                if (addrOut !== e.ao) begin
                    n_fail++;
                    $display("FAIL addrOut: got %h expected %h t=%0t", addrOut, e.ao, $time);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra;
        resetIn = 1'b0;
        readyIn = 1'b0;
        flushIn = 1'b0;
        validIn = 1'b0;
        addrIn  = '0;
        dataIn  = '0;

        // Reset for two cycles, release with the cache stalled
        step(32'h0, 1, 0, 0, 0);
        step(32'h0, 1, 0, 0, 0);
        step(32'h0, 0, 0, 1, 0);
        step(32'h0, 0, 0, 1, 0);

        // Cold miss at 0x104, one word per cycle, then hit
        repeat (7) step(32'h104, 1, 0, 1, 100);

        // Same set, second way; reuse 0x100; conflict miss evicts 0x4100
        repeat (7) step(32'h4100, 1, 0, 1, 100);
        step(32'h100, 1, 0, 1, 100);
        repeat (7) step(32'h8100, 1, 0, 1, 100);
        step(32'h4100, 0, 0, 1, 0);
        step(32'h10C, 0, 0, 1, 0);
        step(32'h8108, 0, 0, 1, 0);

        // Stall for three cycles mid-fill with validIn asserted
        step(32'h600, 1, 0, 1, 0);
        step(32'h600, 1, 0, 1, 100);
        repeat (3) step(32'h600, 0, 0, 1, 100);
        repeat (5) step(32'h604, 1, 0, 1, 100);

        // Flush during the second word of a fill of 0x200
        step(32'h200, 1, 0, 1, 0);
        step(32'h200, 1, 0, 1, 100);
        step(32'h200, 1, 1, 1, 100);
        step(32'h200, 0, 0, 1, 0);
        step(32'h104, 0, 0, 1, 0);

        // Refill 0x104, then serve it while 0x300 is being filled
        repeat (6) step(32'h104, 1, 0, 1, 100);
        step(32'h300, 1, 0, 1, 0);
        step(32'h104, 1, 0, 1, 100);
        step(32'h108, 1, 0, 1, 0);
        repeat (3) step(32'h10C, 1, 0, 1, 100);
        repeat (3) step(32'h304, 1, 0, 1, 100);

        // Randomised traffic against the model
        ra = rand_addr();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(99) < 35) ra = rand_addr();
            step(ra,
                 $urandom_range(99) < 85,
                 $urandom_range(199) == 0,
                 $urandom_range(499) != 0,
                 60);
        end

        repeat (3) @(negedge clk);
        #5;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
